// File: rtl/jbin2bcd_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// Width follows JBIN2BCD_WIDE16_EN: 16-bit operand / 5 digits when defined, else 8-bit / 3 digits.
interface jbin2bcd_seq_if;
`ifdef JBIN2BCD_WIDE16_EN
  localparam int N = 16;
  localparam int D = 5;
`else
  localparam int N = 8;
  localparam int D = 3;
`endif

  logic           start;
  logic [N-1:0]   bin;
  logic           busy;
  logic           done;
  logic [4*D-1:0] bcd;

  modport master (output start, output bin, input busy, input done, input bcd);
  modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/jbin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Macro JBIN2BCD_WIDE16_EN selects the 16-bit/5-digit build; default is 8-bit/3-digit.
module jbin2bcd_seq (
  input  logic              clk,
  input  logic              rst,
  jbin2bcd_seq_if.slave     io,
  output logic [1:0]        dbg_state
);
`ifdef JBIN2BCD_WIDE16_EN
  localparam int N = 16;
  localparam int D = 5;
`else
  localparam int N = 8;
  localparam int D = 3;
`endif
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Handshake: start is taken on any edge where the FSM is in IDLE or DONE;
  // busy marks SHIFT, done is a single-cycle pulse when bcd has just been written.
  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   sr;
  logic [4*D-1:0] scratch;
  logic [4*D-1:0] adj;
  logic [4*D-1:0] bcd_q;

  always_comb begin
    adj = scratch;
    for (int i = 0; i < D; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sr      <= '0;
      scratch <= '0;
      bcd_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.start) begin
            sr      <= io.bin;
            scratch <= '0;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, sr} <= {adj, sr} << 1;
          cnt           <= cnt + CW'(1);
          // The last shift result goes straight to bcd so it lands with DONE.
          if (cnt == CW'(N - 1)) begin
            bcd_q <= {adj[4*D-2:0], sr[N-1]};
            state <= DONE;
          end
        end
        DONE: begin
          if (io.start) begin
            sr      <= io.bin;
            scratch <= '0;
            cnt     <= '0;
            state   <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.busy   = (state == SHIFT);
  assign io.done   = (state == DONE);
  assign io.bcd    = bcd_q;
  assign dbg_state = state;
endmodule

// File: tb/tb_jbin2bcd_seq.sv
// Directed bench for jbin2bcd_seq: reset, latency, back-to-back, ignored start, abort, sweep.
module tb_jbin2bcd_seq;
`ifdef JBIN2BCD_WIDE16_EN
  localparam int N = 16;
  localparam int D = 5;
`else
  localparam int N = 8;
  localparam int D = 3;
`endif
  localparam int BW = 4 * D;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_pass;

  jbin2bcd_seq_if io ();

  jbin2bcd_seq dut (
    .clk       (clk),
    .rst       (rst),
    .io        (io),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [BW-1:0] ref_bcd(input int v);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [BW-1:0] b);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < D; i++)
      if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // Starts one conversion from an idle DUT and checks value, latency, busy span and pulse width.
  task automatic conv_check(input int v, input logic [BW-1:0] exp, input string tag);
    int lat;
    int busy_cyc;
    int overlap;
    @(negedge clk);
    io.start = 1'b1;
    io.bin   = N'(v);
    @(negedge clk);
    io.start = 1'b0;
    io.bin   = ~N'(v);
    lat = 0; busy_cyc = 0; overlap = 0;
    while (!io.done && lat < 40) begin
      if (io.busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    if (io.busy && io.done) overlap++;
    check({tag, "_val"}, 32'(io.bcd), 32'(exp));
    check({tag, "_lat"}, lat, N);
    check({tag, "_busy"}, busy_cyc, N);
    check({tag, "_digits"}, 32'(digits_ok(io.bcd)), 1);
    check({tag, "_overlap"}, overlap, 0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(io.done), 0);
  endtask

  initial begin
    int k;
    int dones;
    logic [BW-1:0] res;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    io.start = 1'b1;
    io.bin   = N'(5);
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(io.busy), 0);
    check("rst_done", 32'(io.done), 0);
    check("rst_bcd", 32'(io.bcd), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst      = 1'b0;
    io.start = 1'b0;

    conv_check(0, 'h000, "zero");
    check("hold_idle", 32'(io.bcd), 'h000);

    // Back-to-back 99 then 255 with start held in the DONE cycle
    @(negedge clk);
    io.start = 1'b1;
    io.bin   = N'(99);
    @(negedge clk);
    io.start = 1'b0;
    k = 0;
    while (!io.done && k < 40) begin @(negedge clk); k++; end
    check("b2b_first", 32'(io.bcd), 'h099);
    io.start = 1'b1;
    io.bin   = N'(255);
    @(negedge clk);
    io.start = 1'b0;
    check("b2b_no_gap", 32'(io.busy), 1);
    check("b2b_hold", 32'(io.bcd), 'h099);
    k = 1;
    while (!io.done && k < 40) begin @(negedge clk); k++; end
    check("b2b_second", 32'(io.bcd), 'h255);
    check("b2b_spacing", k, N + 1);
    @(negedge clk);
    check("b2b_pulse", 32'(io.done), 0);

    // Start pulses and operand changes mid-conversion must be ignored
    @(negedge clk);
    io.start = 1'b1;
    io.bin   = N'(137);
    @(negedge clk);
    io.start = 1'b0;
    dones = 0;
    res   = '0;
    for (int c = 0; c < 30; c++) begin
      if (io.done) begin dones++; res = io.bcd; end
      io.start = (c == 3 || c == 5);
      if (c >= 3) io.bin = N'(42);
      @(negedge clk);
    end
    io.start = 1'b0;
    check("ign_dones", dones, 1);
    check("ign_val", 32'(res), 'h137);

    // Reset mid-conversion aborts it
    @(negedge clk);
    io.start = 1'b1;
    io.bin   = N'(200);
    @(negedge clk);
    io.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(io.busy), 0);
    check("abort_done", 32'(io.done), 0);
    check("abort_bcd", 32'(io.bcd), 0);
    check("abort_state", 32'(dbg_state), 0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (io.done) dones++;
      @(negedge clk);
    end
    check("abort_no_done", dones, 0);
    conv_check(7, 'h007, "after_abort");

`ifdef JBIN2BCD_WIDE16_EN
    conv_check(65535, 'h65535, "max16");
    conv_check(10000, 'h10000, "tenk");
`endif

    for (int v = 0; v < 256; v++)
      conv_check(v, ref_bcd(v), $sformatf("sweep_%0d", v));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
